// File: rtl/storeq_ctl.sv
// Store queue controller: circular head/tail pointers with wrap bits, in-order alloc/dealloc,
// and oldest-first selection of per-entry mem pipe requests with the grant routed back.
module storeq_ctl #(
  parameter int NUM_ENTRIES = 8,
  parameter int ID_W        = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_req_mm0,
  output logic                   alloc_gnt_mm0,
  output logic [ID_W-1:0]        alloc_id_mm0,
  output logic [NUM_ENTRIES-1:0] e_alloc_mm0,
  input  logic [NUM_ENTRIES-1:0] e_valid,
  input  logic [NUM_ENTRIES-1:0] e_pipe_req_mm0,
  output logic [NUM_ENTRIES-1:0] e_pipe_gnt_mm0,
  output logic                   q_pipe_req_mm0,
  output logic [ID_W-1:0]        q_pipe_sel_mm0,
  input  logic                   q_pipe_gnt_mm0,
  output logic                   full,
  output logic                   empty,
  output logic [ID_W:0]          count
);

  logic [ID_W:0]          head_q, head_d, tail_q, tail_d;
  logic [NUM_ENTRIES-1:0] e_valid_q;
  logic [ID_W-1:0]        head_idx, tail_idx, scan_idx;
  logic [NUM_ENTRIES-1:0] req_m;
  logic                   dealloc, found;

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_q[ID_W] != tail_q[ID_W]) && (head_idx == tail_idx);
  assign count = tail_q - head_q;

  assign alloc_gnt_mm0 = alloc_req_mm0 & ~full & ~reset;
  assign alloc_id_mm0  = tail_idx;

  // The head entry is freed on the falling edge of its valid, seen against last cycle's value.
  assign dealloc = ~reset & ~empty & e_valid_q[head_idx] & ~e_valid[head_idx];

  assign head_d = head_q + (ID_W+1)'(dealloc);
  assign tail_d = tail_q + (ID_W+1)'(alloc_gnt_mm0);

  always_comb begin
    e_alloc_mm0 = '0;
    if (alloc_gnt_mm0) e_alloc_mm0[tail_idx] = 1'b1;
  end

  // Scan from head so the first hit is the oldest requesting entry; invalid entries are masked.
  always_comb begin
    req_m          = e_pipe_req_mm0 & e_valid & {NUM_ENTRIES{~reset}};
    found          = 1'b0;
    q_pipe_sel_mm0 = '0;
    scan_idx       = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      scan_idx = head_idx + ID_W'(i);
      if (!found && req_m[scan_idx]) begin
        found          = 1'b1;
        q_pipe_sel_mm0 = scan_idx;
      end
    end
    q_pipe_req_mm0 = found;
    e_pipe_gnt_mm0 = '0;
    if (q_pipe_gnt_mm0 && found) e_pipe_gnt_mm0[q_pipe_sel_mm0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      e_valid_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      e_valid_q <= e_valid;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(q_pipe_gnt_mm0 && !q_pipe_req_mm0))
        else $error("storeq_ctl: pipe grant without request");
      assert (!(alloc_gnt_mm0 && e_valid[tail_idx]))
        else $error("storeq_ctl: alloc into valid entry %0d", tail_idx);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        assert (!(ID_W'(i) != head_idx && e_valid_q[i] && !e_valid[i]))
          else $error("storeq_ctl: non-head entry %0d went idle", i);
      end
    end
  end
`endif

endmodule
